// File: rtl/cue_power_charger_pkg.sv
// Shared types and defaults for the cue shot-power charger.
package cue_pkg;

  localparam int PWR_W         = 8;
  localparam int MAX_POWER_DEF = 120;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE_UP,
    CHARGE_DOWN,
    FIRE,
    WAIT_SETTLE
  } cue_state_t;

  typedef logic [PWR_W-1:0] power_t;

endpackage

// File: rtl/cue_power_charger_key_debounce.sv
// Frame-rate debouncer for the shoot key: samples only on frame ticks and
// emits one-cycle rise/fall pulses when the debounced level changes.
module key_debounce #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic key_raw,
  output logic key_db,
  output logic key_rise,
  output logic key_fall
);

  localparam int CW = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);

  logic [CW-1:0] cnt;
  logic          accept;

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    accept   = 1'b0;
    key_rise = 1'b0;
    key_fall = 1'b0;
    if (tick && (key_raw != key_db) && (cnt == CW'(DEBOUNCE_FRAMES - 1))) begin
      accept   = 1'b1;
      key_rise = key_raw;
      key_fall = ~key_raw;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_db <= 1'b0;
      cnt    <= '0;
    end else if (tick) begin
      if (key_raw == key_db) begin
        cnt <= '0;
      end else if (accept) begin
        key_db <= key_raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cue_power_charger.sv
// Cue shot-power charger: ramps power per frame while the shoot key is held and
// fires a strike on release. Define POWER_PINGPONG_EN to bounce power 0<->MAX.
module cue_power_charger
  import cue_pkg::*;
#(
  parameter int MAX_POWER       = MAX_POWER_DEF,
  parameter int POWER_STEP      = 2,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int SETTLE_FRAMES   = 4,
  parameter int PWR_W           = cue_pkg::PWR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             shoot_key,
  input  logic             balls_moving,
  output logic [PWR_W-1:0] power,
  output logic             charging,
  output logic             shot_strike,
  output logic [PWR_W-1:0] shot_power
);

  localparam int SW = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);
  localparam logic [PWR_W-1:0] MAX_P = PWR_W'(MAX_POWER);

  cue_state_t    state;
  logic [SW-1:0] settle_cnt;
  logic          key_db;
  logic          key_rise;
  logic          key_fall;
  logic          charge_state;
  logic          release_ev;
  logic [PWR_W:0] sum_up;
  logic          up_sat;

  key_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_key_debounce (
    .clk     (clk),
    .reset   (reset),
    .tick    (startOfFrame),
    .key_raw (shoot_key),
    .key_db  (key_db),
    .key_rise(key_rise),
    .key_fall(key_fall)
  );

  // Sum is one bit wider than power so the clamp sees any overflow.
  assign sum_up       = {1'b0, power} + (PWR_W + 1)'(POWER_STEP);
  assign up_sat       = (sum_up >= (PWR_W + 1)'(MAX_POWER));
  assign charge_state = (state == CHARGE_UP) || (state == CHARGE_DOWN);
  // key_db low in a charge state is unreachable; treating it as release keeps
  // the FSM from ever charging with the key already up.
  assign release_ev   = charge_state && (key_fall || !key_db);

`ifdef POWER_PINGPONG_EN
  logic signed [PWR_W:0] diff_dn;
  logic                  dn_zero;
  assign diff_dn = $signed({1'b0, power}) - $signed((PWR_W + 1)'(POWER_STEP));
  assign dn_zero = (diff_dn <= 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      power       <= '0;
      charging    <= 1'b0;
      shot_strike <= 1'b0;
      shot_power  <= '0;
      settle_cnt  <= '0;
    end else begin
      shot_strike <= 1'b0;
      if (release_ev) begin
        // Release wins over a coincident frame tick: that tick's update is dropped.
        charging <= 1'b0;
        if (power != '0) begin
          state       <= FIRE;
          shot_strike <= 1'b1;
          shot_power  <= power;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          IDLE: begin
            power <= '0;
            if (key_rise && !balls_moving) begin
              state    <= CHARGE_UP;
              charging <= 1'b1;
            end
          end

          CHARGE_UP: begin
            if (startOfFrame) begin
              if (up_sat) begin
                power <= MAX_P;
`ifdef POWER_PINGPONG_EN
                state <= CHARGE_DOWN;
`endif
              end else begin
                power <= sum_up[PWR_W-1:0];
              end
            end
          end

`ifdef POWER_PINGPONG_EN
          CHARGE_DOWN: begin
            if (startOfFrame) begin
              if (dn_zero) begin
                power <= '0;
                state <= CHARGE_UP;
              end else begin
                power <= diff_dn[PWR_W-1:0];
              end
            end
          end
`endif

          FIRE: begin
            power      <= '0;
            settle_cnt <= '0;
            state      <= WAIT_SETTLE;
          end

          WAIT_SETTLE: begin
            power <= '0;
            if (balls_moving) begin
              settle_cnt <= '0;
            end else if (startOfFrame) begin
              if (settle_cnt == SW'(SETTLE_FRAMES - 1)) begin
                settle_cnt <= '0;
                state      <= IDLE;
              end else begin
                settle_cnt <= settle_cnt + 1'b1;
              end
            end
          end

          default: begin
            state    <= IDLE;
            power    <= '0;
            charging <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cue_power_charger.sv
// Scoreboard bench for cue_power_charger: frame-level reference model, directed
// scenarios followed by randomized key/ball activity.
module tb_cue_power_charger;

  localparam int MAXP   = 120;
  localparam int STEP   = 2;
  localparam int DBF    = 2;
  localparam int SETTLE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_of_frame = 1'b0;
  logic       shoot_key = 1'b0;
  logic       balls_moving = 1'b0;
  logic [7:0] power;
  logic       charging;
  logic       shot_strike;
  logic [7:0] shot_power;

  int total = 0;
  int bad   = 0;

  cue_power_charger dut (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(start_of_frame),
    .shoot_key   (shoot_key),
    .balls_moving(balls_moving),
    .power       (power),
    .charging    (charging),
    .shot_strike (shot_strike),
    .shot_power  (shot_power)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (frame granularity) ----------------
  typedef enum {M_IDLE, M_CHARGE, M_SETTLE} mmode_t;
  mmode_t m_mode;
  int     m_n;          // charge ticks processed since entry
  int     m_s;          // still-ball settle ticks
  int     m_dbc;        // debounce mismatch count
  bit     m_db;         // debounced key
  int     last_shot;
  int     sb_q[$];

  function automatic int pw(input int n);
`ifdef POWER_PINGPONG_EN
    int per, m;
    per = 2 * MAXP / STEP;
    m   = n % per;
    return ((m <= per / 2) ? m : per - m) * STEP;
`else
    return (n * STEP > MAXP) ? MAXP : n * STEP;
`endif
  endfunction

  function automatic int exp_power();
    return (m_mode == M_CHARGE) ? pw(m_n) : 0;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_s = 0; m_dbc = 0; m_db = 0; last_shot = 0;
  endtask

  task automatic model_tick(input bit key, input bit balls);
    bit rise, fall;
    rise = 0; fall = 0;
    if (key != m_db) begin
      m_dbc++;
      if (m_dbc == DBF) begin
        m_db = key; m_dbc = 0; rise = key; fall = !key;
      end
    end else m_dbc = 0;
    case (m_mode)
      M_IDLE:   if (rise && !balls) begin m_mode = M_CHARGE; m_n = 0; end
      M_CHARGE: begin
        if (fall) begin
          if (pw(m_n) > 0) begin
            sb_q.push_back(pw(m_n)); last_shot = pw(m_n);
            m_mode = M_SETTLE; m_s = 0;
          end else m_mode = M_IDLE;
        end else m_n++;
      end
      default: begin
        if (balls) m_s = 0;
        else begin m_s++; if (m_s == SETTLE) m_mode = M_IDLE; end
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops the expected strike power whenever the DUT strikes.
  bit prev_strike = 0;
  always @(negedge clk) begin
    if (!reset && shot_strike) begin
      check("strike_width", prev_strike, 0);
      if (sb_q.size() == 0) check("strike_unexpected", 1, 0);
      else check("strike_power", shot_power, sb_q.pop_front());
    end
    prev_strike = shot_strike;
  end

  // ---------------- stimulus ----------------
  task automatic frame(input bit key, input bit balls, input int gap);
    shoot_key = key; balls_moving = balls;
    @(negedge clk);
    start_of_frame = 1'b1;
    model_tick(key, balls);
    @(negedge clk);
    start_of_frame = 1'b0;
    repeat (gap) @(negedge clk);
    check("power", power, exp_power());
    check("charging", charging, (m_mode == M_CHARGE) ? 1 : 0);
    check("shot_power_hold", shot_power, last_shot);
  endtask

  task automatic hold(input bit key, input bit balls, input int count);
    for (int i = 0; i < count; i++) frame(key, balls, 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; shoot_key = 1'b0; balls_moving = 1'b0; start_of_frame = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst_power", power, 0);
    check("rst_charging", charging, 0);
    check("rst_strike", shot_strike, 0);
    check("rst_shot_power", shot_power, 0);
  endtask

  initial begin
    bit rk, rb;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // 10 charge ticks then release -> strike of 20
    hold(1, 0, 2);
    hold(1, 0, 9);
    frame(0, 0, 2);
    check("pre_release_power", power, 20);
    frame(0, 0, 2);
    check("shot20", shot_power, 20);
    check("power_after_fire", power, 0);
    hold(0, 0, SETTLE);

    // reset mid-charge at 40: no strike
    hold(1, 0, 2);
    hold(1, 0, 20);
    check("power40", power, 40);
    do_reset();
    repeat (3) begin
      @(negedge clk);
      check("no_strike_after_rst", shot_strike, 0);
    end
    hold(0, 0, 2);

    // long hold: saturate (or bounce with pingpong)
    hold(1, 0, 2);
    hold(1, 0, 60);
    check("power_t60", power, 120);
    hold(1, 0, 20);
`ifdef POWER_PINGPONG_EN
    check("power_t80", power, 80);
`else
    check("power_t80", power, 120);
`endif
    hold(0, 0, 2);
    hold(0, 0, SETTLE);

    // press with balls moving is ignored; new press after settle charges
    hold(1, 1, 4);
    check("balls_block", charging, 0);
    hold(0, 1, 2);
    hold(0, 0, SETTLE);
    hold(1, 0, 2);
    check("recharge", charging, 1);
    hold(0, 0, 2);
    hold(0, 0, SETTLE);

    // single-frame glitch in IDLE
    frame(1, 0, 2);
    frame(0, 0, 2);
    check("glitch_idle", charging, 0);
    // glitch mid-charge is filtered; release tick update dropped -> 30
    hold(1, 0, 2);
    hold(1, 0, 5);
    frame(0, 0, 2);
    frame(1, 0, 2);
    hold(1, 0, 7);
    frame(0, 0, 2);
    check("power30", power, 30);
    frame(0, 0, 2);
    check("shot30", shot_power, 30);
    hold(0, 0, SETTLE);

`ifdef POWER_PINGPONG_EN
    // release exactly at the bottom of the bounce -> IDLE without strike
    hold(1, 0, 2);
    hold(1, 0, 119);
    frame(0, 0, 2);
    check("bottom_power", power, 0);
    frame(0, 0, 2);
    check("bottom_no_fire", charging, 0);
    hold(0, 0, 2);
`else
    // shortest possible press/release
    hold(1, 0, 2);
    hold(0, 0, 2);
    check("short_shot", shot_power, 2);
    hold(0, 0, SETTLE);
`endif

    // randomized activity
    rk = 0; rb = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(4, 0) == 0) rk = !rk;
      if ($urandom_range(7, 0) == 0) rb = !rb;
      if ($urandom_range(149, 0) == 0) do_reset();
      frame(rk, rb, $urandom_range(5, 2));
    end

    hold(0, 0, 2 + SETTLE);
    check("sb_drain", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
